avg_window_ctrl: RTL and testbench



---
 rtl/avg_window_ctrl.sv | 175 +++++++++++++++++
 tb/tb_avg_window_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_window_ctrl.sv
`default_nettype none
// ============================================================================
// avg_window_ctrl : raster-stream 3x3 window scheduler for the avg_apply averager
// Revision        : 1.0
// ============================================================================
module avg_window_ctrl #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_pix_valid,
  input  logic [31:0] i_pix_data,
  output logic        o_pix_ready,
  output logic        o_win_valid,
  output logic [31:0] o_win_1,
  output logic [31:0] o_win_2,
  output logic [31:0] o_win_3,
  output logic [31:0] o_win_4,
  output logic [31:0] o_win_5,
  output logic [31:0] o_win_6,
  output logic [31:0] o_win_7,
  output logic [31:0] o_win_8,
  output logic [31:0] o_win_9,
  input  logic        i_avg_valid,
  input  logic [31:0] i_avg_result,
  output logic        o_res_valid,
  output logic [31:0] o_res_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int c_col_w = $clog2(WIDTH);
  localparam int c_row_w = $clog2(HEIGHT);
  localparam int c_nres  = (WIDTH - 2) * (HEIGHT - 2);
  localparam int c_res_w = $clog2(c_nres + 1);

  localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(WIDTH - 1);
  localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(HEIGHT - 1);
  localparam logic [c_col_w-1:0] c_col_two   = c_col_w'(2);
  localparam logic [c_row_w-1:0] c_row_two   = c_row_w'(2);
  localparam logic [c_res_w-1:0] c_res_total = c_res_w'(c_nres);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_col_w-1:0] r_col;
  logic [c_row_w-1:0] r_row;
  logic [c_res_w-1:0] r_res_cnt;
  logic [31:0]        r_lb0 [WIDTH];
  logic [31:0]        r_lb1 [WIDTH];
  logic [31:0]        r_win [9];
  logic               r_win_valid;
  logic               r_res_valid;
  logic [31:0]        r_res_data;

  logic w_accept;
  logic w_last_pix;
  logic w_issue;

  assign w_accept   = (r_state == S_RUN) && i_pix_valid;
  assign w_last_pix = w_accept && (r_row == c_row_last) && (r_col == c_col_last);
  assign w_issue    = w_accept && (r_row >= c_row_two) && (r_col >= c_col_two);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_pix_ready = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_RUN;
      end
      S_RUN: begin
        o_pix_ready = 1'b1;
        o_busy      = 1'b1;
        if (w_last_pix) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (r_res_cnt == c_res_total) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Position and result counters; results only count while a frame is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_res_cnt   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= o_busy && i_avg_valid;
      if (o_busy && i_avg_valid) r_res_data <= i_avg_result;
      if (r_state == S_IDLE && i_start) begin
        r_col     <= '0;
        r_row     <= '0;
        r_res_cnt <= '0;
      end else begin
        if (w_accept) begin
          if (r_col == c_col_last) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        if (o_busy && i_avg_valid) r_res_cnt <= r_res_cnt + 1'b1;
      end
    end
  end

  // Line buffers carry no reset; row/col gating keeps stale data out of issued windows.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= i_pix_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else begin
      r_win_valid <= w_issue;
      if (w_accept) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= r_lb1[r_col];
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= r_lb0[r_col];
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= i_pix_data;
      end
    end
  end

  assign o_win_valid = r_win_valid;
  assign o_win_1     = r_win[0];
  assign o_win_2     = r_win[1];
  assign o_win_3     = r_win[2];
  assign o_win_4     = r_win[3];
  assign o_win_5     = r_win[4];
  assign o_win_6     = r_win[5];
  assign o_win_7     = r_win[6];
  assign o_win_8     = r_win[7];
  assign o_win_9     = r_win[8];
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_avg_window_ctrl.sv
`default_nettype none
// ============================================================================
// tb_avg_window_ctrl : scoreboard bench, 4x4 and 8x8 instances with a behavioural averager
// Revision           : 1.0
// ============================================================================
module tb_avg_window_ctrl;

  localparam int W0 = 4, H0 = 4, W1 = 8, H1 = 8;
  localparam int LAT0 = 3, LAT1 = 5, LATMAX = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start      [2];
  logic        pix_valid  [2];
  logic [31:0] pix_data   [2];
  logic        pix_ready  [2];
  logic        win_valid  [2];
  logic [31:0] win        [2][9];
  logic        avg_valid  [2];
  logic [31:0] avg_result [2];
  logic        res_valid  [2];
  logic [31:0] res_data   [2];
  logic        busy       [2];
  logic        done       [2];
  logic        inj_v      [2];
  logic [31:0] inj_d      [2];

  avg_window_ctrl #(.WIDTH(W0), .HEIGHT(H0)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_pix_valid(pix_valid[0]),
    .i_pix_data(pix_data[0]), .o_pix_ready(pix_ready[0]), .o_win_valid(win_valid[0]),
    .o_win_1(win[0][0]), .o_win_2(win[0][1]), .o_win_3(win[0][2]),
    .o_win_4(win[0][3]), .o_win_5(win[0][4]), .o_win_6(win[0][5]),
    .o_win_7(win[0][6]), .o_win_8(win[0][7]), .o_win_9(win[0][8]),
    .i_avg_valid(avg_valid[0]), .i_avg_result(avg_result[0]),
    .o_res_valid(res_valid[0]), .o_res_data(res_data[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  avg_window_ctrl #(.WIDTH(W1), .HEIGHT(H1)) u_dut8 (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_pix_valid(pix_valid[1]),
    .i_pix_data(pix_data[1]), .o_pix_ready(pix_ready[1]), .o_win_valid(win_valid[1]),
    .o_win_1(win[1][0]), .o_win_2(win[1][1]), .o_win_3(win[1][2]),
    .o_win_4(win[1][3]), .o_win_5(win[1][4]), .o_win_6(win[1][5]),
    .o_win_7(win[1][6]), .o_win_8(win[1][7]), .o_win_9(win[1][8]),
    .i_avg_valid(avg_valid[1]), .i_avg_result(avg_result[1]),
    .o_res_valid(res_valid[1]), .o_res_data(res_data[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  // ---------------- FP32 helpers (bench-side reference arithmetic) -------------
  function automatic logic [31:0] int2fp(input int v);
    int e;
    logic [31:0] m;
    if (v <= 0) return 32'd0;
    e = 0;
    for (int b = 0; b < 24; b++) if (v[b]) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic real fp2real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2fp(input real x);
    logic [63:0] d;
    logic [10:0] e;
    if (x == 0.0) return 32'd0;
    d = $realtobits(x);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]} + {31'd0, d[28]};
  endfunction

  function automatic logic [31:0] avg_words(input logic [287:0] ws);
    real s;
    s = 0.0;
    for (int i = 0; i < 9; i++) s = s + fp2real(ws[i*32 +: 32]);
    return real2fp(s / 9.0);
  endfunction

  function automatic logic [287:0] dut_window(input int k);
    logic [287:0] p;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = win[k][i];
    return p;
  endfunction

  // ---------------- behavioural averager with per-instance latency -------------
  logic        pipe_v [2][LATMAX];
  logic [31:0] pipe_d [2][LATMAX];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe_v[k][0] <= win_valid[k];
      pipe_d[k][0] <= avg_words(dut_window(k));
      for (int s = 1; s < LATMAX; s++) begin
        pipe_v[k][s] <= pipe_v[k][s-1];
        pipe_d[k][s] <= pipe_d[k][s-1];
      end
    end
  end

  assign avg_valid[0]  = pipe_v[0][LAT0-1] | inj_v[0];
  assign avg_result[0] = inj_v[0] ? inj_d[0] : pipe_d[0][LAT0-1];
  assign avg_valid[1]  = pipe_v[1][LAT1-1] | inj_v[1];
  assign avg_result[1] = inj_v[1] ? inj_d[1] : pipe_d[1][LAT1-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state -------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [287:0] exp_win_q [$];
  logic [31:0]  exp_res_q [$];
  logic [31:0]  res_log   [$];
  logic [31:0]  img [64];
  int win_cnt [2];
  int res_cnt [2];
  int done_cnt[2];
  int last_avg_cyc [2];
  bit cap_win;
  logic [31:0] fw1, fw5, fw9;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [287:0] ew;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (win_valid[k]) begin
          win_cnt[k]++;
          if (k == 0 && cap_win) begin
            fw1 = win[0][0]; fw5 = win[0][4]; fw9 = win[0][8]; cap_win = 1'b0;
          end
          if (exp_win_q.size() == 0) check_val("win_unexpected", 32'd1, 32'd0);
          else begin
            ew = exp_win_q.pop_front();
            for (int i = 0; i < 9; i++)
              check_val($sformatf("win_%0d", i + 1), win[k][i], ew[i*32 +: 32]);
          end
        end
        if (res_valid[k]) begin
          res_cnt[k]++;
          if (k == 0) res_log.push_back(res_data[0]);
          if (exp_res_q.size() == 0) check_val("res_unexpected", 32'd1, 32'd0);
          else check_val("res_data", res_data[k], exp_res_q.pop_front());
        end
        if (avg_valid[k] && !inj_v[k]) last_avg_cyc[k] = cyc;
        if (done[k]) begin
          done_cnt[k]++;
          check_val("done_latency", 32'(cyc - last_avg_cyc[k]), 32'd2);
          check_val("busy_at_done", 32'(busy[k]), 32'd0);
        end
      end
    end
  endtask

  // ---------------- stimulus ---------------------------------------------------
  function automatic void fill_img(input int w, input int h, input int pat);
    for (int i = 0; i < w * h; i++)
      img[i] = (pat == 1) ? 32'h40000000 : int2fp((pat == 2) ? i + 21 : i + 1);
  endfunction

  task automatic push_expect(input int r, input int c, input int w);
    logic [287:0] ew;
    for (int i = 0; i < 9; i++) ew[i*32 +: 32] = img[(r - 2 + i / 3) * w + (c - 2 + i % 3)];
    exp_win_q.push_back(ew);
    exp_res_q.push_back(avg_words(ew));
  endtask

  task automatic drive_pix(input int k, input int r, input int c, input int w);
    bit ok;
    int n;
    ok = 1'b0; n = 0;
    pix_valid[k] = 1'b1;
    pix_data[k]  = img[r * w + c];
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = pix_ready[k];
      if (ok && r >= 2 && c >= 2) push_expect(r, c, w);
      @(posedge clk); #1;
      n++;
    end
    pix_valid[k] = 1'b0;
    if (!ok) check_val("pix_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_frame(input int k);
    @(negedge clk);
    check_val("ready_idle", 32'(pix_ready[k]), 32'd0);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    check_val("ready_after_start", 32'(pix_ready[k]), 32'd1);
    check_val("busy_after_start", 32'(busy[k]), 32'd1);
  endtask

  task automatic run_frame(input int k, input int w, input int h, input int pat,
                           input bit gap, input bit mid_start);
    int w0, r0, d0, n;
    fill_img(w, h, pat);
    w0 = win_cnt[k]; r0 = res_cnt[k]; d0 = done_cnt[k];
    start_frame(k);
    for (int idx = 0; idx < w * h; idx++) begin
      if (mid_start && idx == 5) start[k] = 1'b1;
      drive_pix(k, idx / w, idx % w, w);
      start[k] = 1'b0;
      if (gap) begin @(posedge clk); #1; end
    end
    pix_valid[k] = 1'b1;
    pix_data[k]  = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 pix_valid[k] = 1'b0;
    n = 0;
    while (done_cnt[k] == d0 && n < 500) begin @(negedge clk); n++; end
    if (done_cnt[k] == d0) check_val("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("win_count", 32'(win_cnt[k] - w0), 32'((w - 2) * (h - 2)));
    check_val("res_count", 32'(res_cnt[k] - r0), 32'((w - 2) * (h - 2)));
    check_val("done_count", 32'(done_cnt[k] - d0), 32'd1);
    check_val("busy_after_done", 32'(busy[k]), 32'd0);
    check_val("win_q_left", 32'(exp_win_q.size()), 32'd0);
    check_val("res_q_left", 32'(exp_res_q.size()), 32'd0);
  endtask

  logic [31:0] exp_a [4];

  initial begin
    exp_a[0] = 32'h40C00000; exp_a[1] = 32'h40E00000;
    exp_a[2] = 32'h41200000; exp_a[3] = 32'h41300000;
    for (int k = 0; k < 2; k++) begin
      start[k] = 0; pix_valid[k] = 0; pix_data[k] = 0; inj_v[k] = 0; inj_d[k] = 0;
      win_cnt[k] = 0; res_cnt[k] = 0; done_cnt[k] = 0; last_avg_cyc[k] = 0;
    end
    cap_win = 1'b0;
    rst = 1'b1;
    fork monitor(); join_none
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_val("rst_pix_ready", 32'(pix_ready[0]), 32'd0);
    check_val("rst_win_valid", 32'(win_valid[0]), 32'd0);
    check_val("rst_win_5", win[0][4], 32'd0);
    check_val("rst_res_valid", 32'(res_valid[0]), 32'd0);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    check_val("rst_done", 32'(done[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame A: 4x4 raster 1..16, continuous
    res_log.delete();
    cap_win = 1'b1;
    run_frame(0, W0, H0, 0, 1'b0, 1'b0);
    check_val("A_first_win_1", fw1, 32'h3F800000);
    check_val("A_first_win_5", fw5, 32'h40C00000);
    check_val("A_first_win_9", fw9, 32'h41300000);
    check_val("A_res_log_size", 32'(res_log.size()), 32'd4);
    if (res_log.size() == 4)
      for (int i = 0; i < 4; i++) check_val($sformatf("A_res_%0d", i), res_log[i], exp_a[i]);

    // Frame B: same image with a gap after every pixel
    run_frame(0, W0, H0, 0, 1'b1, 1'b0);

    // Averager results while IDLE must be ignored
    @(negedge clk);
    inj_v[0] = 1'b1; inj_d[0] = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      check_val("idle_res_valid", 32'(res_valid[0]), 32'd0);
    end
    inj_v[0] = 1'b0;
    @(negedge clk);
    check_val("idle_res_valid_after", 32'(res_valid[0]), 32'd0);
    @(posedge clk); #1;

    // Frame C: start re-asserted mid-frame
    run_frame(0, W0, H0, 0, 1'b0, 1'b1);

    // 8x8 all-2.0 frame on the second instance
    run_frame(1, W1, H1, 1, 1'b0, 1'b0);

    // Abort a 4x4 frame after 10 pixels with an asynchronous reset
    fill_img(W0, H0, 0);
    start_frame(0);
    for (int idx = 0; idx < 10; idx++) drive_pix(0, idx / W0, idx % W0, W0);
    rst = 1'b1;
    #1;
    check_val("arst_pix_ready", 32'(pix_ready[0]), 32'd0);
    check_val("arst_busy", 32'(busy[0]), 32'd0);
    check_val("arst_win_9", win[0][8], 32'd0);
    check_val("arst_res_data", res_data[0], 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (LATMAX + 2) @(posedge clk);
    #1;
    run_frame(0, W0, H0, 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
